// File: rtl/uart_tx_core_if.sv
// uart_tx_core_if: parallel-side request signals and serial-side status of the UART transmitter.
interface uart_tx_core_if #(parameter int DATA_WIDTH = 8);
    logic [DATA_WIDTH-1:0] P_DATA;
    logic                  DATA_VALID;
    logic                  PAR_EN;
    logic                  PAR_TYP;
    logic                  TX_OUT;
    logic                  BUSY;
    modport master (output P_DATA, DATA_VALID, PAR_EN, PAR_TYP, input TX_OUT, BUSY);
    modport slave  (input P_DATA, DATA_VALID, PAR_EN, PAR_TYP, output TX_OUT, BUSY);
endinterface

// File: rtl/uart_tx_core.sv
// uart_tx_core: one-bit-per-clock UART framer (start, LSB-first data, optional parity, stop).
module uart_tx_core #(
    parameter int DATA_WIDTH = 8
) (
    input logic          CLK,
    input logic          RST,
    uart_tx_core_if.slave bus
);
    localparam int CW = $clog2(DATA_WIDTH);
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
    state_t                state;
    logic [CW-1:0]         bit_cnt;
    logic [DATA_WIDTH-1:0] data_r;
    logic                  par_en_r;
    logic                  par_r;
    logic                  tx_out;
    logic                  busy;
    logic [CW-1:0]         nxt_cnt;
    logic                  last_bit;
    assign nxt_cnt  = bit_cnt + 1'b1;
    assign last_bit = bit_cnt == CW'(DATA_WIDTH - 1);
    assign bus.TX_OUT = tx_out;
    assign bus.BUSY   = busy;
    // tx_out/busy are loaded with the value belonging to the state being entered
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state    <= IDLE;
            bit_cnt  <= '0;
            data_r   <= '0;
            par_en_r <= 1'b0;
            par_r    <= 1'b0;
            tx_out   <= 1'b1;
            busy     <= 1'b0;
        end else begin
            case (state)
                IDLE, STOP: begin
                    if (bus.DATA_VALID) begin
                        data_r   <= bus.P_DATA;
                        par_en_r <= bus.PAR_EN;
                        par_r    <= (^bus.P_DATA) ^ bus.PAR_TYP;
                        state    <= START;
                        tx_out   <= 1'b0;
                        busy     <= 1'b1;
                    end else begin
                        state  <= IDLE;
                        tx_out <= 1'b1;
                        busy   <= 1'b0;
                    end
                end
                START: begin
                    state   <= DATA;
                    bit_cnt <= '0;
                    tx_out  <= data_r[0];
                end
                DATA: begin
                    if (last_bit) begin
                        bit_cnt <= '0;
                        state   <= par_en_r ? PARITY : STOP;
                        tx_out  <= par_en_r ? par_r : 1'b1;
                    end else begin
                        bit_cnt <= nxt_cnt;
                        tx_out  <= data_r[nxt_cnt];
                    end
                end
                PARITY: begin
                    state  <= STOP;
                    tx_out <= 1'b1;
                end
                default: begin
                    state  <= IDLE;
                    tx_out <= 1'b1;
                    busy   <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_core.sv
// tb_uart_tx_core: directed frame checks for uart_tx_core, one TX_OUT sample per bit period.
module tb_uart_tx_core;
    logic CLK = 1'b0;
    logic RST = 1'b0;
    int n_checks = 0;
    int n_pass = 0;
    uart_tx_core_if #(.DATA_WIDTH(8)) bus ();
    uart_tx_core #(.DATA_WIDTH(8)) dut (.CLK(CLK), .RST(RST), .bus(bus.slave));
    always #5 CLK = ~CLK;
    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask
    task automatic accept(input logic [7:0] d, input logic pen, input logic typ);
        bus.P_DATA = d;
        bus.PAR_EN = pen;
        bus.PAR_TYP = typ;
        bus.DATA_VALID = 1'b1;
        tick();
        bus.DATA_VALID = 1'b0;
    endtask
    // Starts in the start-bit cycle, ends in the stop-bit cycle; par is the hand-computed parity bit.
    task automatic check_frame(input string name, input logic [7:0] d, input logic pen,
                               input logic par, input bit disturb);
        logic [10:0] exp;
        int n;
        exp = pen ? {1'b1, par, d, 1'b0} : {2'b11, d, 1'b0};
        n = pen ? 11 : 10;
        for (int i = 0; i < n; i++) begin
            if (i > 0) tick();
            check($sformatf("%s tx[%0d]", name, i), {7'd0, bus.TX_OUT}, {7'd0, exp[i]});
            check($sformatf("%s busy[%0d]", name, i), {7'd0, bus.BUSY}, 8'd1);
            if (disturb && i == 3) begin
                bus.DATA_VALID = 1'b1;
                bus.P_DATA = ~d;
                bus.PAR_TYP = ~bus.PAR_TYP;
                bus.PAR_EN = ~pen;
            end
            if (disturb && i == 4) bus.DATA_VALID = 1'b0;
        end
    endtask
    task automatic check_idle(input string name);
        check($sformatf("%s tx", name), {7'd0, bus.TX_OUT}, 8'd1);
        check($sformatf("%s busy", name), {7'd0, bus.BUSY}, 8'd0);
    endtask
    initial begin
        bus.P_DATA = 8'h00;
        bus.PAR_EN = 1'b0;
        bus.PAR_TYP = 1'b0;
        bus.DATA_VALID = 1'b0;
        #12;
        check_idle("reset");
        tick();
        RST = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            check_idle($sformatf("idle%0d", i));
        end
        accept(8'hA5, 1'b0, 1'b0);
        check_frame("a5_nopar", 8'hA5, 1'b0, 1'b0, 1'b0);
        tick();
        check_idle("a5_nopar end");
        accept(8'hA5, 1'b1, 1'b0);
        check_frame("a5_even", 8'hA5, 1'b1, 1'b0, 1'b0);
        tick();
        check_idle("a5_even end");
        accept(8'hA5, 1'b1, 1'b1);
        check_frame("a5_odd", 8'hA5, 1'b1, 1'b1, 1'b0);
        tick();
        check_idle("a5_odd end");
        accept(8'h01, 1'b1, 1'b0);
        check_frame("01_even", 8'h01, 1'b1, 1'b1, 1'b0);
        tick();
        check_idle("01_even end");
        accept(8'h3C, 1'b0, 1'b0);
        check_frame("3c_disturbed", 8'h3C, 1'b0, 1'b0, 1'b1);
        bus.P_DATA = 8'hFF;
        bus.PAR_EN = 1'b0;
        bus.PAR_TYP = 1'b0;
        bus.DATA_VALID = 1'b1;
        tick();
        check_frame("ff_b2b", 8'hFF, 1'b0, 1'b0, 1'b0);
        bus.P_DATA = 8'h81;
        tick();
        bus.DATA_VALID = 1'b0;
        check_frame("81_b2b", 8'h81, 1'b0, 1'b0, 1'b0);
        tick();
        check_idle("b2b end");
        accept(8'h00, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) tick();
        check("00 bit3 tx", {7'd0, bus.TX_OUT}, 8'd0);
        #2;
        RST = 1'b0;
        #1;
        check_idle("async reset");
        tick();
        tick();
        check_idle("held reset");
        RST = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_idle($sformatf("post reset%0d", i));
        end
        accept(8'h55, 1'b0, 1'b0);
        check_frame("55_after_rst", 8'h55, 1'b0, 1'b0, 1'b0);
        tick();
        check_idle("55 end");
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/uart_tx_core.md
# uart_tx_core

Serial UART transmitter: accepts a parallel byte with a one-cycle valid strobe and shifts out a frame. The frame is start bit, 8 data bits LSB first, optional parity bit, and one stop bit. It is the transmit-side counterpart of the UART receiver datapath and sits between the system-side TX FIFO/handshake logic and the TX pin. CLK is the baud-rate clock produced by the clock divider, so one CLK cycle equals one bit period.

## Interface
- DATA_WIDTH, 8, number of data bits per frame

- CLK  input  1  baud-rate clock; one bit per cycle
- RST  input  1  asynchronous, active-low reset
- P_DATA  input  DATA_WIDTH  parallel data to transmit
- DATA_VALID  input  1  request to send P_DATA; sampled only on accept edges
- PAR_EN  input  1  1 = insert parity bit after data
- PAR_TYP  input  1  0 = even parity, 1 = odd parity
- TX_OUT  output  1  serial line, registered; idle high
- BUSY  output  1  registered; high while a frame is on the line

## Operation
- FSM states: IDLE, START, DATA, PARITY, STOP.
- **Accept edge:** a rising CLK edge where state is IDLE or STOP and DATA_VALID=1.
- On an accept edge:
  - Latch P_DATA, PAR_EN and PAR_TYP into internal registers.
  - Latch parity = (^P_DATA) XOR PAR_TYP.
  - Next state is START.
- Inputs are ignored at all other edges. Changes to P_DATA, PAR_EN or PAR_TYP mid-frame have no effect.
- Transitions:
  - IDLE → START on accept; otherwise stay in IDLE.
  - START → DATA.
  - DATA → DATA while bit counter < DATA_WIDTH-1.
  - DATA → PARITY when the last bit is reached and latched PAR_EN=1.
  - DATA → STOP when the last bit is reached and latched PAR_EN=0.
  - PARITY → STOP.
  - STOP → START on accept; otherwise STOP → IDLE.
- Bit counter:
  - 3 bits for DATA_WIDTH=8; clears entering DATA.
  - Increments once per DATA cycle and wraps to 0 on leaving DATA.
- TX_OUT by state: IDLE=1, START=0, DATA=data[bit_cnt], PARITY=latched parity, STOP=1.
- TX_OUT and BUSY are registered from next-state logic, so they change on the same edge as the state register.
- Frame length: 10 cycles (PAR_EN=0) or 11 cycles (PAR_EN=1).

## Timing
- Reset values: TX_OUT=1, BUSY=0, state=IDLE, bit counter=0, data/parity registers=0.
- RST asserted mid-frame aborts the frame immediately. TX_OUT returns to 1 and BUSY to 0 asynchronously, and no partial frame resumes after RST deasserts.
- Accept at edge k:
  - Start bit is on TX_OUT from edge k until edge k+1.
  - Data bit i occupies the cycle from edge k+1+i.
  - Parity occupies the cycle from edge k+9 (PAR_EN=1).
  - Stop occupies the cycle from edge k+9 (PAR_EN=0) or k+10 (PAR_EN=1).
- BUSY goes high at edge k. It falls at the edge ending the stop bit only if there is no accept at that edge.
- Back-to-back: DATA_VALID=1 at the edge ending the stop bit starts the next start bit with no idle gap. BUSY stays high continuously.
- DATA_VALID held high continuously produces continuous frames, one accept per frame.
- Latency from accept edge to start bit on pin: 0 cycles (registered at the accept edge).

## Test plan
- **Reset/idle:** assert RST → TX_OUT=1, BUSY=0. Release RST with DATA_VALID=0 for 20 cycles → TX_OUT stays 1, BUSY stays 0.
- **No parity:** P_DATA=0xA5, PAR_EN=0, DATA_VALID pulse 1 cycle → TX_OUT = 0,1,0,1,0,0,1,0,1,1, then idle 1. BUSY high for exactly 10 cycles.
- **Parity variants:** 0xA5 with PAR_EN=1, PAR_TYP=0 → parity bit 0, 11-cycle frame. Same byte with PAR_TYP=1 → parity bit 1. Also 0x01 even → parity 1.
- **Back-to-back and mid-frame isolation:**
  - Send 0x3C, then hold DATA_VALID=1 with P_DATA=0xFF at the stop-end edge → stop bit immediately followed by start bit, no idle cycle. BUSY never drops between frames.
  - Changing P_DATA/PAR_TYP and pulsing DATA_VALID mid-frame does not alter the current frame.
- **Reset mid-frame:** start a 0x00 frame and assert RST during data bit 3 → TX_OUT=1 and BUSY=0 immediately. After release, a new 0x55 frame is transmitted correctly from its start bit.
